// File: rtl/pwm_duty_capture.sv
// PWM duty/period capture: synchronises one PWM waveform, measures high time and
// period between rising edges, and reports constant-level inputs via a timeout.
module pwm_duty_capture #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned CNT_WIDTH    = 12,
  parameter int unsigned PERIOD_TOL   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] duty_out,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 duty_valid,
  output logic                 period_err,
  output logic                 stuck
);

  localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] Interval = CNT_WIDTH'(PWM_INTERVAL);
  localparam logic [CNT_WIDTH-1:0] TickLast = CNT_WIDTH'(PWM_INTERVAL - 1);
  localparam logic [CNT_WIDTH-1:0] Timeout  = CNT_WIDTH'(2 * PWM_INTERVAL - 1);
  localparam logic [CNT_WIDTH:0]   Tol      = (CNT_WIDTH + 1)'(PERIOD_TOL);

  typedef enum logic [1:0] {StWaitEdge, StMeasure, StStuck} state_e;

  state_e               state_q;
  logic                 pwm_meta_q, pwm_s_q, pwm_d_q;
  logic [CNT_WIDTH-1:0] per_cnt_q, high_cnt_q, tick_cnt_q;
  logic [CNT_WIDTH-1:0] duty_q, period_q;
  logic                 valid_q, err_q, stuck_q;

  logic                 rise;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] per_cnt_d, high_cnt_d;
  logic [CNT_WIDTH-1:0] period_meas, duty_meas;
  logic signed [CNT_WIDTH:0] per_diff;
  logic [CNT_WIDTH:0]   per_abs;
  logic                 err_meas;
  logic [CNT_WIDTH-1:0] stuck_duty;

  assign rise    = pwm_s_q & ~pwm_d_q;
  assign timeout = (per_cnt_q == Timeout);

  // Next counter values and the measurement that a rising edge would report.
  always_comb begin
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    if (rise) begin
      per_cnt_d  = '0;
      high_cnt_d = CNT_WIDTH'(1);
    end else begin
      if (per_cnt_q != CntMax) per_cnt_d = per_cnt_q + 1'b1;
      if (pwm_s_q && (high_cnt_q != CntMax)) high_cnt_d = high_cnt_q + 1'b1;
    end
    // In MEASURE per_cnt never passes Timeout, so +1 cannot wrap here.
    period_meas = per_cnt_q + 1'b1;
    duty_meas   = (high_cnt_q > period_meas) ? period_meas : high_cnt_q;
    per_diff    = $signed({1'b0, period_meas}) - $signed({1'b0, Interval});
    per_abs     = per_diff[CNT_WIDTH] ? $unsigned(-per_diff) : $unsigned(per_diff);
    err_meas    = (per_abs > Tol);
    stuck_duty  = pwm_s_q ? Interval : '0;
  end

  // Input synchroniser, edge-detect delay flop and free-running measurement counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_meta_q <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_d_q    <= 1'b0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
    end else begin
      pwm_meta_q <= pwm_in;
      pwm_s_q    <= pwm_meta_q;
      pwm_d_q    <= pwm_s_q;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  // Capture FSM with registered result outputs; rise always beats timeout or tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWaitEdge;
      tick_cnt_q <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StWaitEdge, StMeasure: begin
          if (rise) begin
            // The first edge after reset only arms the measurement.
            if (state_q == StMeasure) begin
              duty_q   <= duty_meas;
              period_q <= period_meas;
              err_q    <= err_meas;
              valid_q  <= 1'b1;
            end
            state_q <= StMeasure;
          end else if (timeout) begin
            state_q    <= StStuck;
            stuck_q    <= 1'b1;
            tick_cnt_q <= '0;
            duty_q     <= stuck_duty;
            period_q   <= Interval;
            err_q      <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        StStuck: begin
          if (rise) begin
            // Partial period before this edge is not reported.
            state_q <= StMeasure;
            stuck_q <= 1'b0;
          end else if (tick_cnt_q == TickLast) begin
            tick_cnt_q <= '0;
            duty_q     <= stuck_duty;
            period_q   <= Interval;
            err_q      <= 1'b0;
            valid_q    <= 1'b1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StWaitEdge;
          stuck_q <= 1'b0;
        end
      endcase
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign duty_valid = valid_q;
  assign period_err = err_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: drives PWM waveforms, records strobes at negedge.
module tb_pwm_duty_capture;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic [11:0] duty_out, period_out;
  logic        duty_valid, period_err, stuck;

  int n_vec, n_err;
  int cyc;
  int n_strobe, last_strobe_cyc, prev_strobe_cyc;
  int last_duty, last_period, last_err;
  int n_stuck_rise, stuck_rise_cyc, stuck_fall_cyc;
  logic prev_dv, prev_stuck;

  pwm_duty_capture #(
    .PWM_INTERVAL(1200),
    .CNT_WIDTH   (12),
    .PERIOD_TOL  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .period_out(period_out),
    .duty_valid(duty_valid),
    .period_err(period_err),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe/stuck recorder; cyc here equals the number of posedges seen so far.
  always @(negedge clk) begin
    if (duty_valid) begin
      check_eq("dv_back_to_back", 32'(prev_dv), 0);
      check_eq("duty_le_period", 32'(duty_out <= period_out), 1);
      n_strobe++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      last_duty   = int'(duty_out);
      last_period = int'(period_out);
      last_err    = int'(period_err);
    end
    if (stuck && !prev_stuck) begin
      n_stuck_rise++;
      stuck_rise_cyc = cyc;
    end
    if (!stuck && prev_stuck) stuck_fall_cyc = cyc;
    prev_dv    = duty_valid;
    prev_stuck = stuck;
  end

  task automatic drive(input int period, input int high);
    for (int i = 0; i < period; i++) begin
      pwm_in = (i < high);
      @(negedge clk);
    end
  endtask

  task automatic check_report(input string tag, input int n, input int duty, input int per,
                              input int err);
    check_eq({tag, "_count"}, n_strobe, n);
    check_eq({tag, "_duty"}, last_duty, duty);
    check_eq({tag, "_period"}, last_period, per);
    check_eq({tag, "_err"}, last_err, err);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_duty"}, 32'(duty_out), 0);
    check_eq({tag, "_period"}, 32'(period_out), 0);
    check_eq({tag, "_valid"}, 32'(duty_valid), 0);
    check_eq({tag, "_err"}, 32'(period_err), 0);
    check_eq({tag, "_stuck"}, 32'(stuck), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, snap;
    n_vec = 0; n_err = 0; cyc = 0;
    n_strobe = 0; last_strobe_cyc = 0; prev_strobe_cyc = 0;
    last_duty = -1; last_period = -1; last_err = -1;
    n_stuck_rise = 0; stuck_rise_cyc = 0; stuck_fall_cyc = 0;
    prev_dv = 1'b0; prev_stuck = 1'b0;
    rst_n = 1'b0; pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // First edge only arms; each later edge reports the period just finished.
    drive(1200, 300);
    check_eq("first_edge_no_strobe", n_strobe, 0);
    c = cyc;
    drive(1200, 300);
    check_report("p300_a", 1, 300, 1200, 0);
    // pwm_in set before posedge c+1, strobe visible after posedge c+3.
    check_eq("strobe_latency", last_strobe_cyc - c, 3);
    drive(1200, 1);
    check_report("p300_b", 2, 300, 1200, 0);
    drive(1200, 600);
    check_report("h1", 3, 1, 1200, 0);
    drive(1200, 1199);
    check_report("h600", 4, 600, 1200, 0);
    drive(1300, 650);
    check_report("h1199", 5, 1199, 1200, 0);
    drive(1202, 601);
    check_report("p1300", 6, 650, 1300, 1);
    c = cyc;
    drive(1200, 300);
    check_report("p1202", 7, 601, 1202, 0);

    // Hold low: last rise cycle follows posedge c+2, per_cnt hits 2399 after posedge c+2402,
    // STUCK entry strobe at c+2403, ticks at c+3603, c+4803, c+6003.
    repeat (5000) @(negedge clk);
    check_report("stuck_lo", 11, 0, 1200, 0);
    check_eq("stuck_lo_level", 32'(stuck), 1);
    check_eq("stuck_lo_entry", stuck_rise_cyc - c, 2403);
    check_eq("stuck_tick_spacing", last_strobe_cyc - prev_strobe_cyc, 1200);

    // Hold high: the rise leaves STUCK silently, then timeout re-enters with full duty.
    c = cyc;
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("stuck_exit_level", 32'(stuck), 0);
    check_eq("stuck_exit_no_strobe", n_strobe, 11);
    repeat (4990) @(negedge clk);
    check_report("stuck_hi", 14, 1200, 1200, 0);
    check_eq("stuck_hi_level", 32'(stuck), 1);
    check_eq("stuck_hi_entry", stuck_rise_cyc - c, 2403);

    // Resume toggling: first rise clears stuck without a strobe.
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    c = cyc;
    drive(1200, 300);
    check_eq("resume_fall", stuck_fall_cyc - c, 3);
    check_eq("resume_no_strobe", n_strobe, 14);
    check_eq("resume_level", 32'(stuck), 0);
    drive(1200, 450);
    check_report("resume", 15, 300, 1200, 0);

    // Reset for one clock mid high phase; the complete period afterwards is exact.
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    check_report("pre_rst", 16, 450, 1200, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    rst_n = 1'b1;
    repeat (99) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1000) @(negedge clk);
    drive(1200, 300);
    c = cyc;
    drive(1200, 450);
    check_eq("post_rst_fresh", last_strobe_cyc - c, 3);
    check_eq("post_rst_duty", last_duty, 300);
    check_eq("post_rst_period", last_period, 1200);
    check_eq("post_rst_err", last_err, 0);

    // Rise lands exactly when per_cnt == 2399: stays in MEASURE, reports 2400.
    snap = n_stuck_rise;
    drive(2400, 1200);
    c = cyc;
    drive(1200, 300);
    check_eq("coinc_fresh", last_strobe_cyc - c, 3);
    check_eq("coinc_duty", last_duty, 1200);
    check_eq("coinc_period", last_period, 2400);
    check_eq("coinc_err", last_err, 1);
    check_eq("coinc_no_stuck", n_stuck_rise - snap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- Receive-side counterpart to the board's RGB PWM fade generators: samples one PWM waveform and recovers its high time and period in clk cycles.
- Used for on-chip loopback checking of the fade channels, and as a decoder for an externally driven PWM pin.
- Reports a constant-level input (0% or 100% duty) through a timeout, not as silence.

Parameters:
- PWM_INTERVAL, 1200, nominal PWM period in clk cycles; full-scale duty value.
- CNT_WIDTH, 12, width of all counters and outputs; must satisfy 2^CNT_WIDTH > 2*PWM_INTERVAL.
- PERIOD_TOL, 2, allowed |period - PWM_INTERVAL| before period_err is flagged.

Ports:
- clk  input  1  system clock (12 MHz on board).
- rst_n  input  1  reset; synchronous, active-low.
- pwm_in  input  1  asynchronous PWM waveform.
- duty_out  output  CNT_WIDTH  high cycles of the last complete period.
- period_out  output  CNT_WIDTH  cycles between the last two rising edges (PWM_INTERVAL while stuck).
- duty_valid  output  1  one-cycle strobe; duty_out, period_out and period_err are updated on the cycle it is high.
- period_err  output  1  measured period is outside tolerance; valid with duty_valid.
- stuck  output  1  level high while no rising edge has been seen for the timeout.

Behaviour:
- Synchronous active-low reset:
  - All outputs go to 0, counters to 0, state to WAIT_EDGE.
  - Both synchronizer flops go to 0.
  - Reset mid-period discards the partial measurement.
- Input path:
  - Two-flop synchronizer gives pwm_s; a delay flop gives pwm_d.
  - rise = pwm_s & ~pwm_d.
  - If pwm_in is first sampled high at clk edge E, rise is high in the cycle after edge E+1.
  - duty_valid is high in the cycle after edge E+2.
- Counters, updated every cycle in every state, saturating at all-ones:
  - per_cnt: on rise <= 0, else <= per_cnt+1.
  - high_cnt: on rise <= 1, else <= high_cnt + pwm_s.
- TIMEOUT = 2*PWM_INTERVAL-1.
- State WAIT_EDGE (first, partial period after reset is not reported):
  - rise -> MEASURE, with no strobe.
  - per_cnt == TIMEOUT -> STUCK.
- State MEASURE:
  - On rise: duty_out <= high_cnt; period_out <= per_cnt+1; period_err <= (|per_cnt+1 - PWM_INTERVAL| > PERIOD_TOL); duty_valid <= 1.
  - per_cnt == TIMEOUT with no rise -> STUCK.
- State STUCK:
  - stuck = 1.
  - On entry, and then every PWM_INTERVAL cycles (free-running tick counter, reset on entry): duty_out <= (pwm_s ? PWM_INTERVAL : 0); period_out <= PWM_INTERVAL; period_err <= 0; duty_valid <= 1.
  - rise -> MEASURE: stuck <= 0, no strobe for that edge; the next complete period is reported normally.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins.
  - In STUCK, rise and tick in the same cycle: rise wins, no strobe.
- Arithmetic:
  - The period difference is computed at CNT_WIDTH+1 bits, signed.
  - duty_out never exceeds period_out.
- duty_valid:
  - Exactly one cycle wide.
  - Never high in two consecutive cycles.
  - Never high in the cycle following reset deassertion.

Test Plan:
- Reset, then 1200-cycle period at 300 high for 3 periods -> no strobe for the first edge; then duty_out=300, period_out=1200, period_err=0 on each later edge; duty_valid asserted 3 edges after pwm_in rises.
- Sweep high time 1, 600, 1199 at period 1200 -> duty_out=1, 600, 1199; period_out=1200.
- Period 1300, high 650 -> duty_out=650, period_out=1300, period_err=1. Period 1202 -> period_err=0.
- Hold pwm_in low 5000 cycles after a valid period -> stuck=1 at 2399 cycles after the last rise; strobes every 1200 cycles with duty_out=0. Repeat holding high -> duty_out=1200. Then resume toggling -> stuck=0 at the first rise; the next period is reported normally.
- Assert rst_n=0 for 1 cycle mid high phase -> all outputs 0; the next edge gives no strobe; the following complete period is correct.
- Rise coincident with per_cnt==TIMEOUT -> stays in MEASURE and reports period_out=2400.
